// File: rtl/bus_pkg.sv
// Shared system-bus definitions: target FSM encoding, framing constants and the
// counter sizing helper used by the serial target and its wait timer.
package bus_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        WDATA = 3'd2,
        MEM   = 3'd3,
        RESP  = 3'd4
    } bus_tgt_state_t;

    localparam logic BUS_RW_WRITE   = 1'b1;
    localparam logic BUS_STATUS_OK  = 1'b1;
    localparam logic BUS_STATUS_ERR = 1'b0;

    // Width that holds any bit index of a frame field and any wait count up to TIMEOUT.
    function automatic int bus_cnt_w(input int addr_w, input int data_w, input int timeout);
        int m;
        m = (addr_w > data_w) ? addr_w : data_w;
        m = (timeout + 1 > m) ? timeout + 1 : m;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// Counts cycles spent waiting on the local memory port and flags the last
// permitted cycle; TIMEOUT = 0 disables expiry entirely.
module bus_wait_timer #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_count,
    output logic o_expire
);

    // TIMEOUT = 0 wraps this to all ones, but w_enabled gates it out.
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             w_enabled;
    logic [CNT_W-1:0] r_cnt;

    assign w_enabled = (TIMEOUT != 0) ? 1'b1 : 1'b0;

    // Wait counter: cleared while loading, advances while counting, parks at LAST.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_count && w_enabled && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + CNT_ONE;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_expire = w_enabled & i_count & (r_cnt == LAST);

endmodule

// File: rtl/bus_target_port.sv
// Bit-serial bus target: deserialises a read/write request frame, performs one
// access on the local request/ready port and serialises status (+ read data) back.
module bus_target_port
    import bus_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m_valid,
    input  logic              m_data,
    output logic              s_valid,
    output logic              s_data,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = bus_cnt_w(ADDR_W, DATA_W, TIMEOUT);

    localparam logic [2:0] ST_IDLE  = IDLE;
    localparam logic [2:0] ST_ADDR  = ADDR;
    localparam logic [2:0] ST_WDATA = WDATA;
    localparam logic [2:0] ST_MEM   = MEM;
    localparam logic [2:0] ST_RESP  = RESP;

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_rw;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_status;
    logic              r_resp_last;
    logic              r_mem_req;
    logic              r_mem_we;
    logic              r_s_valid;
    logic              r_s_data;
    logic              r_busy;

    logic [2:0]        w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_rw_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [DATA_W-1:0] w_wdata_nxt;
    logic [DATA_W-1:0] w_rdata_nxt;
    logic              w_status_nxt;
    logic              w_resp_last_nxt;
    logic              w_mem_req_nxt;
    logic              w_mem_we_nxt;
    logic              w_s_valid_nxt;
    logic              w_s_data_nxt;
    logic              w_busy_nxt;

    logic              w_timer_load;
    logic              w_timer_count;
    logic              w_expire;

    assign w_timer_load  = (r_state != ST_MEM);
    assign w_timer_count = (r_state == ST_MEM);

    bus_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_timer_load),
        .i_count  (w_timer_count),
        .o_expire (w_expire)
    );

    // Next-state and next-output logic; every output register is loaded from here.
    always_comb begin
        w_state_nxt     = r_state;
        w_rw_nxt        = r_rw;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_rdata_nxt     = r_rdata;
        w_status_nxt    = r_status;
        w_resp_last_nxt = r_resp_last;
        w_s_valid_nxt   = 1'b0;
        w_s_data_nxt    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (m_valid) begin
                    w_rw_nxt    = m_data;
                    w_state_nxt = ST_ADDR;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (!m_valid) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_addr_nxt = {r_addr[ADDR_W-2:0], m_data};
                    if (r_cnt == ADDR_LAST) begin
                        w_state_nxt = (r_rw == BUS_RW_WRITE) ? ST_WDATA : ST_MEM;
                    end else begin
                        w_state_nxt = ST_ADDR;
                    end
                end
            end
            ST_WDATA: begin
                if (!m_valid) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_wdata_nxt = {r_wdata[DATA_W-2:0], m_data};
                    if (r_cnt == DATA_LAST) begin
                        w_state_nxt = ST_MEM;
                    end else begin
                        w_state_nxt = ST_WDATA;
                    end
                end
            end
            ST_MEM: begin
                // A ready in the final permitted cycle still wins over the timeout.
                if (r_mem_req && mem_ready) begin
                    w_rdata_nxt     = (r_rw == BUS_RW_WRITE) ? r_rdata : mem_rdata;
                    w_status_nxt    = BUS_STATUS_OK;
                    w_resp_last_nxt = (r_rw == BUS_RW_WRITE);
                    w_s_valid_nxt   = 1'b1;
                    w_s_data_nxt    = BUS_STATUS_OK;
                    w_state_nxt     = ST_RESP;
                end else if (w_expire) begin
                    w_status_nxt    = BUS_STATUS_ERR;
                    w_resp_last_nxt = 1'b1;
                    w_s_valid_nxt   = 1'b1;
                    w_s_data_nxt    = BUS_STATUS_ERR;
                    w_state_nxt     = ST_RESP;
                end else begin
                    w_state_nxt = ST_MEM;
                end
            end
            ST_RESP: begin
                if (r_resp_last) begin
                    w_resp_last_nxt = 1'b0;
                    w_state_nxt     = ST_IDLE;
                end else begin
                    w_s_valid_nxt   = 1'b1;
                    w_s_data_nxt    = r_rdata[DATA_W-1];
                    w_rdata_nxt     = {r_rdata[DATA_W-2:0], 1'b0};
                    w_resp_last_nxt = (r_cnt == DATA_LAST);
                    w_state_nxt     = ST_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_state_nxt == ST_MEM) begin
            w_mem_req_nxt = 1'b1;
            w_mem_we_nxt  = r_rw;
        end else begin
            w_mem_req_nxt = 1'b0;
            w_mem_we_nxt  = 1'b0;
        end

        if ((w_state_nxt != r_state) || (r_state == ST_IDLE)) begin
            w_cnt_nxt = '0;
        end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
        end

        // busy already drops while the final response bit is on the line.
        w_busy_nxt = (w_state_nxt != ST_IDLE) && !((w_state_nxt == ST_RESP) && w_resp_last_nxt);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_rw        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_status    <= 1'b0;
            r_resp_last <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_s_valid   <= 1'b0;
            r_s_data    <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rw        <= w_rw_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_rdata     <= w_rdata_nxt;
            r_status    <= w_status_nxt;
            r_resp_last <= w_resp_last_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_s_valid   <= w_s_valid_nxt;
            r_s_data    <= w_s_data_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign s_valid   = r_s_valid;
    assign s_data    = r_s_data;
    assign busy      = r_busy;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_bus_target_port.sv
// Directed bench for bus_target_port: per-cycle expectation table plus
// hand-written timeout and mid-response reset sequences.
module tb_bus_target_port;

    logic       clk = 1'b0;
    logic       rst;
    logic       m_valid, m_data, mem_ready;
    logic [7:0] mem_rdata;
    logic       s_valid, s_data, busy, mem_req, mem_we;
    logic [7:0] mem_addr, mem_wdata;

    logic       to_m_valid, to_m_data, to_mem_ready;
    logic [7:0] to_mem_rdata;
    logic       to_s_valid, to_s_data, to_busy, to_mem_req, to_mem_we;
    logic [7:0] to_mem_addr, to_mem_wdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bus_target_port #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .m_valid(m_valid), .m_data(m_data),
        .s_valid(s_valid), .s_data(s_data), .busy(busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    bus_target_port #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(4)) dut_to (
        .clk(clk), .rst(rst), .m_valid(to_m_valid), .m_data(to_m_data),
        .s_valid(to_s_valid), .s_data(to_s_data), .busy(to_busy),
        .mem_req(to_mem_req), .mem_we(to_mem_we), .mem_addr(to_mem_addr), .mem_wdata(to_mem_wdata),
        .mem_ready(to_mem_ready), .mem_rdata(to_mem_rdata)
    );

    typedef struct {
        logic       mv, md, rdy;
        logic [7:0] rdata;
        logic       req, we, sv, sd, bsy, ca, cw;
        logic [7:0] addr, wdata;
    } vec_t;

    vec_t q[$];

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d got=%0h want=%0h", name, idx, act, exp);
        end
    endtask

    task automatic push(input logic mv, md, rdy, input logic [7:0] rdata,
                        input logic req, we, sv, sd, bsy, ca, cw,
                        input logic [7:0] addr, wdata);
        vec_t v;
        v.mv = mv; v.md = md; v.rdy = rdy; v.rdata = rdata;
        v.req = req; v.we = we; v.sv = sv; v.sd = sd; v.bsy = bsy;
        v.ca = ca; v.cw = cw; v.addr = addr; v.wdata = wdata;
        q.push_back(v);
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++)
            push(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    // Write: rw bit, 8 address bits, 8 data bits, dly+1 MEM cycles, one status bit.
    task automatic add_write(input logic [7:0] a, input logic [7:0] d, input int dly);
        push(1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int i = 7; i >= 0; i--)
            push(1'b1, a[i], 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int i = 7; i >= 0; i--)
            push(1'b1, d[i], 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i <= dly; i++)
            push(1'b0, 1'b0, (i == dly) ? 1'b1 : 1'b0, 8'hEE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, a, d);
        push(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    // Read: rw bit, 8 address bits, dly+1 MEM cycles, status + 8 data bits MSB first.
    task automatic add_read(input logic [7:0] a, input int dly, input logic [7:0] rd, input logic noise);
        push(1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int i = 7; i >= 0; i--)
            push(1'b1, a[i], 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i <= dly; i++)
            push(noise, noise, (i == dly) ? 1'b1 : 1'b0, (i == dly) ? rd : 8'hEE,
                 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, a, 8'h00);
        push(noise, noise, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int i = 7; i >= 0; i--)
            push(noise, noise, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, rd[i], (i != 0) ? 1'b1 : 1'b0,
                 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    // Abort: write rw bit, 4 address bits, then m_valid drops.
    task automatic add_abort();
        logic [3:0] bits;
        bits = 4'b1011;
        push(1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int i = 3; i >= 0; i--)
            push(1'b1, bits[i], 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        push(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic run_queue(input string tag);
        for (int i = 0; i < q.size(); i++) begin
            @(posedge clk); #1;
            m_valid   = q[i].mv;
            m_data    = q[i].md;
            mem_ready = q[i].rdy;
            mem_rdata = q[i].rdata;
            @(negedge clk);
            chk({tag, ".mem_req"}, i, {7'h00, mem_req}, {7'h00, q[i].req});
            chk({tag, ".mem_we"},  i, {7'h00, mem_we},  {7'h00, q[i].we});
            chk({tag, ".s_valid"}, i, {7'h00, s_valid}, {7'h00, q[i].sv});
            chk({tag, ".s_data"},  i, {7'h00, s_data},  {7'h00, q[i].sd});
            chk({tag, ".busy"},    i, {7'h00, busy},    {7'h00, q[i].bsy});
            if (q[i].ca) chk({tag, ".mem_addr"},  i, mem_addr,  q[i].addr);
            if (q[i].cw) chk({tag, ".mem_wdata"}, i, mem_wdata, q[i].wdata);
        end
        q.delete();
    endtask

    // TIMEOUT=4 instance, mem_ready held low: 4 request cycles then a lone ERR bit.
    task automatic run_timeout();
        logic [8:0] frame;
        int req_cnt, first_req, last_req, sv_cnt, sv_idx;
        logic sv_data, sv_busy, we_seen;
        logic [7:0] addr_seen;
        frame = {1'b0, 8'h55};
        req_cnt = 0; first_req = -1; last_req = -1; sv_cnt = 0; sv_idx = -1;
        sv_data = 1'b1; sv_busy = 1'b1; we_seen = 1'b0; addr_seen = 8'h00;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            to_m_valid = 1'b1; to_m_data = frame[8-i]; to_mem_ready = 1'b0;
        end
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            to_m_valid = 1'b0; to_m_data = 1'b0;
            @(negedge clk);
            if (to_mem_req) begin
                req_cnt++;
                last_req = c;
                if (first_req < 0) begin
                    first_req = c;
                    addr_seen = to_mem_addr;
                end
            end
            if (to_s_valid) begin
                sv_cnt++;
                sv_idx  = c;
                sv_data = to_s_data;
                sv_busy = to_busy;
            end
            if (to_mem_we) we_seen = 1'b1;
        end
        chk("to.req_cycles", 0, 8'(req_cnt), 8'd4);
        chk("to.req_first",  0, 8'(first_req), 8'd0);
        chk("to.req_last",   0, 8'(last_req), 8'd3);
        chk("to.mem_addr",   0, addr_seen, 8'h55);
        chk("to.mem_we",     0, {7'h00, we_seen}, 8'h00);
        chk("to.sv_count",   0, 8'(sv_cnt), 8'd1);
        chk("to.sv_cycle",   0, 8'(sv_idx), 8'd4);
        chk("to.status",     0, {7'h00, sv_data}, 8'h00);
        chk("to.sv_busy",    0, {7'h00, sv_busy}, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        m_valid = 1'b0; m_data = 1'b0; mem_ready = 1'b0; mem_rdata = 8'h00;
        to_m_valid = 1'b0; to_m_data = 1'b0; to_mem_ready = 1'b0; to_mem_rdata = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.s_valid",   0, {7'h00, s_valid}, 8'h00);
        chk("rst.s_data",    0, {7'h00, s_data},  8'h00);
        chk("rst.busy",      0, {7'h00, busy},    8'h00);
        chk("rst.mem_req",   0, {7'h00, mem_req}, 8'h00);
        chk("rst.mem_we",    0, {7'h00, mem_we},  8'h00);
        chk("rst.mem_addr",  0, mem_addr,  8'h00);
        chk("rst.mem_wdata", 0, mem_wdata, 8'h00);
        chk("rst.to_busy",   0, {7'h00, to_busy}, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;

        add_idle(2);
        add_write(8'h3C, 8'hA5, 0);
        add_idle(1);
        add_read(8'h81, 3, 8'h5A, 1'b0);
        add_idle(2);
        add_abort();
        add_write(8'h10, 8'h3E, 1);
        add_write(8'h22, 8'h99, 0);
        add_write(8'h23, 8'h66, 2);
        add_read(8'hF0, 0, 8'hC3, 1'b1);
        add_idle(2);
        run_queue("seq");

        run_timeout();

        // Reset while the third read data bit is on the line.
        add_idle(1);
        add_read(8'h81, 0, 8'h5A, 1'b0);
        while (q.size() > 15) void'(q.pop_back());
        run_queue("pre_rst");
        #2;
        rst = 1'b1;
        #1;
        chk("midrst.s_valid",   0, {7'h00, s_valid}, 8'h00);
        chk("midrst.s_data",    0, {7'h00, s_data},  8'h00);
        chk("midrst.busy",      0, {7'h00, busy},    8'h00);
        chk("midrst.mem_req",   0, {7'h00, mem_req}, 8'h00);
        chk("midrst.mem_addr",  0, mem_addr,  8'h00);
        chk("midrst.mem_wdata", 0, mem_wdata, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;
        add_idle(2);
        add_write(8'h47, 8'h18, 1);
        add_idle(1);
        run_queue("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
